// File: rtl/nn_cfg_pkg.sv
// nn_cfg_pkg: shared network configuration for the layer sequencer.
//   - layer count, index widths and in-flight limit
//   - per-layer neuron counts and fan-in tables (layer 1 is entry 0)
//   - sequencer state type and table lookup helpers (1-based layer index)
package nn_cfg_pkg;

  localparam int unsigned NUM_LAYERS = 4;
  localparam int unsigned LAYER_W    = 3;
  localparam int unsigned NEURON_W   = 6;
  localparam int unsigned MAX_OUT    = 4;
  localparam int unsigned FANIN_W    = 16;

  typedef logic [LAYER_W-1:0]  layer_t;
  typedef logic [NEURON_W-1:0] neuron_t;
  typedef logic [FANIN_W-1:0]  fanin_t;

  localparam neuron_t LAYER_SIZE [NUM_LAYERS] = '{6'd30, 6'd30, 6'd10, 6'd10};
  localparam fanin_t  LAYER_FANIN[NUM_LAYERS] = '{16'd784, 16'd30, 16'd30, 16'd10};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } seq_state_e;

  // Neuron count of a 1-based layer; 0 for an out-of-range layer.
  function automatic neuron_t layer_size(input layer_t layer);
    neuron_t r;
    r = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer == LAYER_W'(i + 1)) r = LAYER_SIZE[i];
    end
    return r;
  endfunction

  // Fan-in of a 1-based layer; 0 for an out-of-range layer.
  function automatic fanin_t layer_fanin(input layer_t layer);
    fanin_t r;
    r = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer == LAYER_W'(i + 1)) r = LAYER_FANIN[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/nn_outstanding_ctr.sv
// nn_outstanding_ctr: saturating up/down count of jobs in flight.
//   ACLK, ARESETN : clock, synchronous active-low reset
//   clr_i         : force count to zero (wins over inc/dec)
//   inc_i, dec_i  : job issued / job result returned (both -> unchanged)
//   full_o        : count will equal MAX after this edge
//   zero_o        : count will be zero after this edge
//   underflow_o   : dec_i while the count is already zero (count stays 0)
// The flags describe the post-edge count so that registered consumers in
// the parent see them aligned with the count they gate.
module nn_outstanding_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic zero_o,
  output logic underflow_o
);

  localparam int unsigned   CW    = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          up, down;

  always_comb begin
    up    = inc_i && (cnt_q != MAX_C);
    down  = dec_i && (cnt_q != '0);
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (up && !down)   cnt_d = cnt_q + 1'b1;
    else if (down && !up)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign full_o      = (cnt_d == MAX_C);
  assign zero_o      = (cnt_d == '0);
  assign underflow_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: walks every (layer, neuron) job of the network and
// issues them to the neuron datapath, holding a barrier between layers.
//   ACLK, ARESETN      : clock, synchronous active-low reset
//   start, abort       : begin a pass when idle / cancel the pass
//   busy, done         : pass in progress / one-cycle pass-complete pulse
//   layer_done         : one-cycle pulse when a layer's last result returns
//   issue_valid/ready  : job handshake; layer_idx, neuron_idx (1-based),
//                        fan_in, last_in_layer describe the presented job
//   result_valid       : one job completed by the datapath
//   err                : sticky, result returned with nothing in flight
// Optional macro NN_LAYER_SEQ_PERF_EN adds cycle_count and stall_count.
// All outputs are registered.
module nn_layer_sequencer #(
  parameter int unsigned NUM_LAYERS = nn_cfg_pkg::NUM_LAYERS,
  parameter int unsigned LAYER_W    = nn_cfg_pkg::LAYER_W,
  parameter int unsigned NEURON_W   = nn_cfg_pkg::NEURON_W,
  parameter int unsigned MAX_OUT    = nn_cfg_pkg::MAX_OUT
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                layer_done,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [LAYER_W-1:0]  layer_idx,
  output logic [NEURON_W-1:0] neuron_idx,
  output logic [15:0]         fan_in,
  output logic                last_in_layer,
  input  logic                result_valid,
  output logic                err
`ifdef NN_LAYER_SEQ_PERF_EN
 ,output logic [31:0]         cycle_count
 ,output logic [31:0]         stall_count
`endif
);

  import nn_cfg_pkg::*;

  localparam logic [LAYER_W-1:0]  LAYER_ONE  = LAYER_W'(1);
  localparam logic [NEURON_W-1:0] NEURON_ONE = NEURON_W'(1);

  seq_state_e          state_q, state_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic [NEURON_W-1:0] neuron_q, neuron_d;
  logic [15:0]         fan_q, fan_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ldone_q, ldone_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  logic accept;
  logic ctr_full, ctr_zero, ctr_underflow;

  assign accept = valid_q && issue_ready;

  nn_outstanding_ctr #(
    .MAX (MAX_OUT)
  ) u_outstanding (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .clr_i       (abort),
    .inc_i       (accept),
    .dec_i       (result_valid),
    .full_o      (ctr_full),
    .zero_o      (ctr_zero),
    .underflow_o (ctr_underflow)
  );

  // State and registered outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= ST_IDLE;
      layer_q  <= LAYER_ONE;
      neuron_q <= NEURON_ONE;
      fan_q    <= layer_fanin(layer_t'(LAYER_ONE));
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ldone_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      fan_q    <= fan_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ldone_q  <= ldone_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  // Next state and job indices.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    if (abort) begin
      state_d  = ST_IDLE;
      layer_d  = LAYER_ONE;
      neuron_d = NEURON_ONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_ISSUE;
            layer_d  = LAYER_ONE;
            neuron_d = NEURON_ONE;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            if (last_q) state_d  = ST_DRAIN;
            else        neuron_d = neuron_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // ctr_zero already folds in a result returning this cycle, so
          // the next layer is presented on the very next cycle.
          if (ctr_zero) begin
            if (layer_q == LAYER_W'(NUM_LAYERS)) begin
              state_d = ST_FINISH;
            end else begin
              state_d  = ST_ISSUE;
              layer_d  = layer_q + 1'b1;
              neuron_d = NEURON_ONE;
            end
          end
        end
        ST_FINISH: begin
          state_d  = ST_IDLE;
          layer_d  = LAYER_ONE;
          neuron_d = NEURON_ONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output values for the coming cycle.
  always_comb begin
    valid_d = (state_d == ST_ISSUE) && !ctr_full;
    busy_d  = (state_d != ST_IDLE);
    done_d  = !abort && (state_q == ST_FINISH);
    ldone_d = !abort && (state_q == ST_DRAIN) && ctr_zero;
    fan_d   = 16'(layer_fanin(layer_t'(layer_d)));
    last_d  = (neuron_d == NEURON_W'(layer_size(layer_t'(layer_d))));
    err_d   = err_q || ctr_underflow;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign layer_done    = ldone_q;
  assign issue_valid   = valid_q;
  assign layer_idx     = layer_q;
  assign neuron_idx    = neuron_q;
  assign fan_in        = fan_q;
  assign last_in_layer = last_q;
  assign err           = err_q;

`ifdef NN_LAYER_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d, stall_q, stall_d;

  always_comb begin
    cyc_d   = cyc_q;
    stall_d = stall_q;
    if (!abort && (state_q == ST_IDLE) && start) begin
      cyc_d   = '0;
      stall_d = '0;
    end else begin
      if (busy_q && (cyc_q != '1))                        cyc_d   = cyc_q + 1'b1;
      if (valid_q && !issue_ready && (stall_q != '1))     stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
    end
  end

  assign cycle_count = cyc_q;
  assign stall_count = stall_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: a pass-level reference model tracks what
// the sequencer must present each cycle; a small datapath stand-in accepts
// jobs and returns results after a chosen delay.
module tb_nn_layer_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        issue_ready = 1'b0;
  logic        result_valid = 1'b0;
  logic        busy, done, layer_done, issue_valid, last_in_layer, err;
  logic [2:0]  layer_idx;
  logic [5:0]  neuron_idx;
  logic [15:0] fan_in;

  always #5 ACLK = ~ACLK;

  nn_layer_sequencer #(
    .NUM_LAYERS (4),
    .LAYER_W    (3),
    .NEURON_W   (6),
    .MAX_OUT    (4)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .layer_done    (layer_done),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .layer_idx     (layer_idx),
    .neuron_idx    (neuron_idx),
    .fan_in        (fan_in),
    .last_in_layer (last_in_layer),
    .result_valid  (result_valid),
    .err           (err)
  );

  int total = 0;
  int bad   = 0;

  int sz[4] = '{30, 30, 10, 10};
  int fi[4] = '{784, 30, 30, 10};

  // Reference model: pass progress plus expected outputs.
  bit m_run, m_wait, m_close;
  int m_layer, m_neuron, m_out;
  bit e_busy, e_done, e_ldone, e_valid, e_last, e_err;
  int e_fanin;

  // Datapath stand-in.
  int q[$];
  int cyc = 0;
  int delay = 2;
  bit hold = 0;
  int credits = 0;
  bit extra_rv = 0;
  bit rand_delay = 0;
  bit slow_l1 = 0;

  int acc_n = 0, ldone_n = 0, done_n = 0;
  bit done_seen = 0;
  bit track_seq = 0;
  int exp_n = 1;
  bit track_l2 = 0;
  bit seen2 = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_wait = 0; m_close = 0;
    m_layer = 1; m_neuron = 1; m_out = 0;
    e_busy = 0; e_done = 0; e_ldone = 0; e_valid = 0; e_last = 0; e_err = 0;
    e_fanin = fi[0];
  endfunction

  function automatic void model_step(input bit st, input bit ab, input bit rdy, input bit rv);
    bit acc;
    int o;
    acc = e_valid && rdy;
    e_done  = 0;
    e_ldone = 0;
    e_err   = e_err || (rv && m_out == 0);
    if (ab) begin
      m_run = 0; m_wait = 0; m_close = 0;
      m_layer = 1; m_neuron = 1; m_out = 0;
    end else begin
      o = m_out + (acc ? 1 : 0) - ((rv && m_out > 0) ? 1 : 0);
      if (!m_run) begin
        if (st) begin m_run = 1; m_layer = 1; m_neuron = 1; end
      end else if (m_close) begin
        m_run = 0; m_close = 0; e_done = 1; m_layer = 1; m_neuron = 1;
      end else if (m_wait) begin
        if (o == 0) begin
          e_ldone = 1;
          m_wait  = 0;
          if (m_layer == 4) m_close = 1;
          else begin m_layer++; m_neuron = 1; end
        end
      end else if (acc) begin
        if (m_neuron == sz[m_layer-1]) m_wait = 1;
        else m_neuron++;
      end
      m_out = o;
    end
    e_busy  = m_run;
    e_valid = m_run && !m_wait && !m_close && (m_out < 4);
    e_fanin = fi[m_layer-1];
    e_last  = (m_neuron == sz[m_layer-1]);
  endfunction

  task automatic check_all();
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("layer_done", layer_done, e_ldone);
    chk("issue_valid", issue_valid, e_valid);
    chk("err", err, e_err);
    if (e_valid || !e_busy) begin
      chk("layer_idx", layer_idx, m_layer);
      chk("neuron_idx", neuron_idx, m_neuron);
      chk("fan_in", fan_in, e_fanin);
      chk("last_in_layer", last_in_layer, e_last);
    end
    if (done) begin done_n++; done_seen = 1; end
    if (layer_done) ldone_n++;
  endtask

  // One clock: called at a negedge with inputs set, returns at the next negedge.
  task automatic tick();
    bit rv, acc, stall;
    logic [2:0]  pl;
    logic [5:0]  pn;
    logic [15:0] pf;
    int d;
    rv = extra_rv;
    if (!rv && q.size() > 0 && q[0] <= cyc && (!hold || credits > 0)) begin
      rv = 1;
      void'(q.pop_front());
      if (hold) credits--;
    end
    result_valid = rv;
    acc   = issue_valid && issue_ready;
    stall = issue_valid && !issue_ready;
    pl = layer_idx; pn = neuron_idx; pf = fan_in;
    @(posedge ACLK);
    #1;
    if (!ARESETN) model_reset();
    else          model_step(start, abort, issue_ready, rv);
    cyc++;
    if (acc) begin
      acc_n++;
      if (rand_delay)            d = int'($urandom_range(5, 1));
      else if (slow_l1 && pl == 1) d = 10;
      else                        d = delay;
      q.push_back(cyc + d);
      if (track_seq && pl == 1) begin
        chk("seq_neuron", pn, exp_n);
        exp_n++;
      end
    end
    @(negedge ACLK);
    if (stall && !abort) begin
      chk("hold_layer", layer_idx, pl);
      chk("hold_neuron", neuron_idx, pn);
      chk("hold_fanin", fan_in, pf);
    end
    if (ARESETN) check_all();
    if (track_l2 && !seen2 && issue_valid && layer_idx == 2) begin
      seen2 = 1;
      chk("D_l2_neuron", neuron_idx, 1);
      chk("D_l2_fanin", fan_in, 30);
      chk("D_l2_layer_done", layer_done, 1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int maxc, input string name);
    done_seen = 0;
    for (int i = 0; i < maxc && !done_seen; i++) tick();
    chk(name, done_seen, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    tick();
    tick();
    ARESETN = 1'b1;

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_valid", issue_valid, 0);
    chk("rst_layer", layer_idx, 1);
    chk("rst_neuron", neuron_idx, 1);
    chk("rst_fanin", fan_in, 784);
    chk("rst_last", last_in_layer, 0);
    chk("rst_err", err, 0);
    tick();

    // Full pass, ready high, results two cycles after acceptance.
    issue_ready = 1'b1;
    acc_n = 0; ldone_n = 0; done_n = 0;
    pulse_start();
    chk("A_first_valid", issue_valid, 1);
    chk("A_busy", busy, 1);
    run_until_done(1000, "A_done_timeout");
    chk("A_accepts", acc_n, 80);
    chk("A_layer_dones", ldone_n, 4);
    chk("A_done_count", done_n, 1);
    chk("A_err", err, 0);
    chk("A_busy_after", busy, 0);
    tick();

    // Results withheld: in-flight limit, then one release.
    hold = 1; credits = 0; acc_n = 0;
    pulse_start();
    repeat (20) tick();
    chk("B_accepts_capped", acc_n, 4);
    chk("B_valid_low", issue_valid, 0);
    credits = 1;
    repeat (10) tick();
    chk("B_one_more", acc_n, 5);
    chk("B_valid_low2", issue_valid, 0);
    hold = 0;
    run_until_done(2000, "B_done_timeout");
    chk("B_total_accepts", acc_n, 80);
    tick();

    // Random ready and random result latency.
    rand_delay = 1; track_seq = 1; exp_n = 1;
    pulse_start();
    done_seen = 0;
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      issue_ready = 1'($urandom_range(1, 0));
      tick();
    end
    chk("C_done_timeout", done_seen, 1);
    chk("C_layer1_len", exp_n, 31);
    rand_delay = 0; track_seq = 0; issue_ready = 1'b1;
    tick();

    // Slow layer-1 results: barrier before layer 2.
    slow_l1 = 1; track_l2 = 1; seen2 = 0;
    pulse_start();
    run_until_done(2000, "D_done_timeout");
    chk("D_saw_layer2", seen2, 1);
    slow_l1 = 0; track_l2 = 0;
    tick();

    // Abort at layer 3 neuron 5, then restart.
    done_n = 0;
    pulse_start();
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (issue_valid && layer_idx == 3 && neuron_idx == 5) found = 1;
      else tick();
    end
    chk("E_reached", found, 1);
    q.delete();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    q.delete();
    chk("E_busy", busy, 0);
    chk("E_valid", issue_valid, 0);
    chk("E_done", done, 0);
    repeat (3) tick();
    chk("E_no_done", done_n, 0);
    pulse_start();
    chk("E_restart_valid", issue_valid, 1);
    chk("E_restart_layer", layer_idx, 1);
    chk("E_restart_neuron", neuron_idx, 1);
    chk("E_restart_fanin", fan_in, 784);
    run_until_done(2000, "E_done_timeout");
    chk("E_done_count", done_n, 1);
    tick();

    // Start while busy is ignored.
    done_n = 0;
    pulse_start();
    repeat (30) tick();
    pulse_start();
    run_until_done(2000, "F_done_timeout");
    repeat (10) tick();
    chk("F_done_once", done_n, 1);
    chk("F_idle", busy, 0);
    chk("F_err_clean", err, 0);

    // Spurious result while idle sets sticky err.
    extra_rv = 1;
    tick();
    extra_rv = 0;
    tick();
    chk("G_err_set", err, 1);
    repeat (5) tick();
    chk("G_err_sticky", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

- Sequences neuron evaluations across the network's layers and hands each (layer, neuron) job to the shared neuron compute datapath over a valid/ready issue channel.
- Tracks in-flight jobs and enforces a layer barrier: no job of layer L+1 issues until every result of layer L has returned.
- Sits between the top-level network control (start/done) and the neuron datapath.

## Interface
Parameters:
- NUM_LAYERS, 4, number of layers sequenced
- LAYER_W, 3, width of layer index
- NEURON_W, 6, width of neuron index
- MAX_OUT, 4, maximum jobs in flight (issued, result not yet returned)

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, synchronous, active-low
- start  in  1  pulse; begins a full network pass when idle
- abort  in  1  synchronous cancel of the current pass
- busy  out  1  high from the cycle after accepted start until done/abort
- done  out  1  one-cycle pulse after the last result of the last layer
- layer_done  out  1  one-cycle pulse when a layer's last result returns
- issue_valid  out  1  job presented
- issue_ready  in  1  datapath accepts job
- layer_idx  out  LAYER_W  1-based layer of presented job
- neuron_idx  out  NEURON_W  1-based neuron of presented job
- fan_in  out  16  inputs feeding that neuron (per-layer constant)
- last_in_layer  out  1  presented job is the layer's final neuron
- result_valid  in  1  datapath reports one job complete
- err  out  1  sticky: result_valid seen with zero in flight

## Operation
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: start=1 -> ISSUE with layer 1, neuron 1. start is ignored in all other states.
- ISSUE: issue_valid=1 unless outstanding==MAX_OUT. On valid&ready:
  - outstanding+1;
  - neuron+1; or, if last_in_layer, go to DRAIN.
- DRAIN: wait for outstanding==0. Then pulse layer_done and:
  - next layer -> ISSUE, neuron 1; or
  - after layer NUM_LAYERS -> FINISH.
- FINISH: pulse done, go to IDLE; indices return to 1.
- result_valid decrements outstanding in any state. A simultaneous accept and result leaves outstanding unchanged. result_valid with outstanding==0 sets err, count stays 0. err clears only on reset.
- abort, any state: next cycle IDLE, outstanding=0, indices=1, no done/layer_done. Results still returning afterwards set err. The datapath must be flushed by the owner.
- Layer sizes and fan-in come from package tables: sizes 30,30,10,10; fan_in 784,30,30,10.
- Outstanding counter width is clog2(MAX_OUT+1). It never wraps.

## Timing
- Reset values: busy=0, done=0, layer_done=0, issue_valid=0, layer_idx=1, neuron_idx=1, fan_in=784, last_in_layer=0, err=0, state IDLE.
- Start to first issue_valid: 1 cycle.
- Back-to-back issue: zero bubbles while ready=1 and outstanding<MAX_OUT.
- Once issue_valid is high, the job fields stay stable until accepted. Only abort may drop valid early.
- Cycle where the last result of a layer lowers outstanding to 0: layer_done is registered high on the next cycle. In that same next cycle, issue_valid asserts for the next layer's neuron 1.
- Last layer: done asserts one cycle after layer_done, and busy falls in that same cycle.
- All outputs are registered.

## Configuration
- NN_LAYER_SEQ_PERF_EN defined: adds output port cycle_count (32 bits).
  - Cleared on accepted start; increments every busy cycle; saturates at all-ones; holds after done.
  - Adds output stall_count (32 bits): counts cycles with issue_valid&!issue_ready.
- Undefined: neither port nor either counter exists.

## Structure
- Package nn_cfg_pkg holds:
  - NUM_LAYERS;
  - LAYER_SIZE and LAYER_FANIN constant arrays;
  - state enum typedef;
  - index width constants.
- One sub-module, nn_outstanding_ctr: up/down counter with full flag, zero flag and underflow flag. It drives issue gating and err.

## Test plan
- ready=1, results returned 2 cycles after each accept -> 80 accepts. layer_done at the end of each of the 4 layers, done once, err=0.
- Results withheld during layer 1 -> exactly 4 accepts, then issue_valid=0. Releasing one result allows exactly one more accept.
- ready toggling 1/0 -> layer_idx, neuron_idx and fan_in stay stable while valid&!ready. The neuron sequence runs 1..30 with no gaps.
- Last layer-1 accept, results delayed 10 cycles -> no layer-2 issue until the cycle after outstanding hits 0. Layer 2 then starts with neuron 1, fan_in=30.
- abort at layer 3 neuron 5 -> next cycle busy=0 and issue_valid=0, with no done. A later start restarts at layer 1 neuron 1.
- result_valid while idle -> err=1 persists. A start pulse during busy is ignored.
